// File: rtl/counter12_monitor.sv
// counter12_monitor
// Passive checker for a mod-12 up/down counter. It taps the counter's
// controls and output, predicts each next count, and reports mismatches,
// out-of-range values, error statistics and wrap-around statistics.
// Nothing is driven back into the counter.
module counter12_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mon_en,
  input  logic             load,
  input  logic             mode,
  input  logic [3:0]       data_in,
  input  logic [3:0]       count_in,
  output logic [3:0]       exp_out,
  output logic             chk_valid,
  output logic             err_mismatch,
  output logic             err_range,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] wrap_up_cnt,
  output logic [CNT_W-1:0] wrap_dn_cnt
);

  localparam logic [3:0] CNT_MAX = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;

  logic [3:0]       exp_q, exp_d;
  // Record of how the armed prediction was formed, so a later matched
  // check can be attributed to an 11->0 or 0->11 step (never a load).
  logic             up_wrap_pend_q, up_wrap_pend_d;
  logic             dn_wrap_pend_q, dn_wrap_pend_d;

  logic             mismatch_q, mismatch_d;
  logic             range_q, range_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] wrap_up_q, wrap_up_d;
  logic [CNT_W-1:0] wrap_dn_q, wrap_dn_d;

  // FSM-decoded strobes
  logic             cmp_en;     // comparison happens on this edge
  logic             watch_en;   // ARM or CHECK with monitoring enabled
  logic             pred_en;    // prediction register reloads on this edge

  // Derived comparison results
  logic [3:0]       pred;
  logic             matched;
  logic             any_err;

  // Next count of the observed counter, identical to the counter's own
  // update including how illegal values (12..15) propagate.
  function automatic logic [3:0] predict_next(
    input logic       ld,
    input logic       md,
    input logic [3:0] d,
    input logic [3:0] c
  );
    logic [3:0] r;
    if (ld) begin
      r = d;
    end else if (!md) begin
      r = (c == CNT_MAX) ? 4'd0 : c + 4'd1;
    end else begin
      r = (c == 4'd0) ? CNT_MAX : c - 4'd1;
    end
    return r;
  endfunction

  // State register; reset lands in CHECK when monitoring is enabled because
  // the counter clears on the same edge, so the prediction of 0 is valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= mon_en ? ST_CHECK : ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> ARM -> CHECK while enabled, back to IDLE otherwise.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = mon_en ? ST_ARM : ST_IDLE;
      ST_ARM:   state_d = mon_en ? ST_CHECK : ST_IDLE;
      ST_CHECK: state_d = mon_en ? ST_CHECK : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output/strobe decode from the current state.
  always_comb begin
    chk_valid = 1'b0;
    cmp_en    = 1'b0;
    watch_en  = 1'b0;
    pred_en   = 1'b0;
    case (state_q)
      ST_ARM: begin
        watch_en = mon_en;
        pred_en  = 1'b1;
      end
      ST_CHECK: begin
        chk_valid = 1'b1;
        cmp_en    = mon_en;
        watch_en  = mon_en;
        pred_en   = 1'b1;
      end
      default: begin
        chk_valid = 1'b0;
      end
    endcase
  end

  // Comparison and range detection on the current observed count.
  always_comb begin
    pred       = predict_next(load, mode, data_in, count_in);
    mismatch_d = cmp_en && (count_in != exp_q);
    matched    = cmp_en && (count_in == exp_q);
    range_d    = watch_en && (count_in > CNT_MAX);
    any_err    = mismatch_d || range_d;
    sticky_d   = sticky_q || any_err;
  end

  // Prediction reload: built from the observed value, so a mismatch is
  // followed by automatic resynchronisation on the next cycle.
  always_comb begin
    exp_d          = exp_q;
    up_wrap_pend_d = up_wrap_pend_q;
    dn_wrap_pend_d = dn_wrap_pend_q;
    if (pred_en) begin
      exp_d          = pred;
      up_wrap_pend_d = !load && !mode && (count_in == CNT_MAX);
      dn_wrap_pend_d = !load &&  mode && (count_in == 4'd0);
    end
  end

  // Statistics: saturating error count, free-rolling wrap counts.
  always_comb begin
    err_cnt_d = err_cnt_q;
    wrap_up_d = wrap_up_q;
    wrap_dn_d = wrap_dn_q;
    if (any_err && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
    if (matched && up_wrap_pend_q) begin
      wrap_up_d = wrap_up_q + CNT_W'(1);
    end
    if (matched && dn_wrap_pend_q) begin
      wrap_dn_d = wrap_dn_q + CNT_W'(1);
    end
  end

  // Datapath registers; reset discards any in-flight prediction.
  always_ff @(posedge clock) begin
    if (reset) begin
      exp_q          <= 4'd0;
      up_wrap_pend_q <= 1'b0;
      dn_wrap_pend_q <= 1'b0;
      mismatch_q     <= 1'b0;
      range_q        <= 1'b0;
      sticky_q       <= 1'b0;
      err_cnt_q      <= '0;
      wrap_up_q      <= '0;
      wrap_dn_q      <= '0;
    end else begin
      exp_q          <= exp_d;
      up_wrap_pend_q <= up_wrap_pend_d;
      dn_wrap_pend_q <= dn_wrap_pend_d;
      mismatch_q     <= mismatch_d;
      range_q        <= range_d;
      sticky_q       <= sticky_d;
      err_cnt_q      <= err_cnt_d;
      wrap_up_q      <= wrap_up_d;
      wrap_dn_q      <= wrap_dn_d;
    end
  end

  assign exp_out      = exp_q;
  assign err_mismatch = mismatch_q;
  assign err_range    = range_q;
  assign err_sticky   = sticky_q;
  assign err_cnt      = err_cnt_q;
  assign wrap_up_cnt  = wrap_up_q;
  assign wrap_dn_cnt  = wrap_dn_q;

endmodule

// File: tb/tb_counter12_monitor.sv
// Testbench for counter12_monitor: a behavioural counter drives count_in
// (with optional forced values) and a reference model of the monitor's
// rules predicts every output after each clock edge.
module tb_counter12_monitor;

  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset, mon_en, load, mode;
  logic [3:0]       data_in, count_in;
  logic [3:0]       exp_out;
  logic             chk_valid, err_mismatch, err_range, err_sticky;
  logic [CNT_W-1:0] err_cnt, wrap_up_cnt, wrap_dn_cnt;

  int checks = 0;
  int errors = 0;
  int stepno = 0;

  // Behavioural counter state
  int cnt = 0;

  // Reference model: phase = number of consecutive enabled edges since idle,
  // capped at 2 (0 idle, 1 arming, 2 checking).
  int phase = 0;
  int m_exp = 0;
  int m_kind = 0;   // 0 normal step or load, 1 up-wrap step, 2 down-wrap step
  int m_mis = 0, m_rng = 0, m_sticky = 0;
  int m_ec = 0, m_wu = 0, m_wd = 0;

  counter12_monitor #(.CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .mon_en      (mon_en),
    .load        (load),
    .mode        (mode),
    .data_in     (data_in),
    .count_in    (count_in),
    .exp_out     (exp_out),
    .chk_valid   (chk_valid),
    .err_mismatch(err_mismatch),
    .err_range   (err_range),
    .err_sticky  (err_sticky),
    .err_cnt     (err_cnt),
    .wrap_up_cnt (wrap_up_cnt),
    .wrap_dn_cnt (wrap_dn_cnt)
  );

  always #5 clock = ~clock;

  function automatic int next_count(int ld, int md, int d, int c);
    if (ld != 0) return d;
    if (md == 0) return (c == 11) ? 0 : (c + 1) % 16;
    return (c == 0) ? 11 : c - 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (step %0d)", tag, obs, expv, stepno);
    end
  endtask

  // One clock cycle: drive inputs, advance model, check after the edge.
  task automatic step(input int rst_v, input int en_v, input int ld_v, input int md_v,
                      input int d_v, input int force_v);
    int mis, rng, hit;
    if (force_v >= 0) cnt = force_v;
    reset    = rst_v[0];
    mon_en   = en_v[0];
    load     = ld_v[0];
    mode     = md_v[0];
    data_in  = d_v[3:0];
    count_in = cnt[3:0];

    if (rst_v != 0) begin
      phase = (en_v != 0) ? 2 : 0;
      m_exp = 0; m_kind = 0;
      m_mis = 0; m_rng = 0; m_sticky = 0;
      m_ec = 0; m_wu = 0; m_wd = 0;
    end else begin
      mis = (phase == 2 && en_v != 0 && cnt != m_exp) ? 1 : 0;
      hit = (phase == 2 && en_v != 0 && cnt == m_exp) ? 1 : 0;
      rng = (phase >= 1 && en_v != 0 && cnt > 11) ? 1 : 0;
      if (hit != 0 && m_kind == 1) m_wu = (m_wu + 1) % (CMAX + 1);
      if (hit != 0 && m_kind == 2) m_wd = (m_wd + 1) % (CMAX + 1);
      if (mis != 0 || rng != 0) begin
        m_sticky = 1;
        if (m_ec < CMAX) m_ec++;
      end
      m_mis = mis;
      m_rng = rng;
      if (phase >= 1) begin
        m_exp = next_count(ld_v, md_v, d_v, cnt);
        if (ld_v == 0 && md_v == 0 && cnt == 11)      m_kind = 1;
        else if (ld_v == 0 && md_v != 0 && cnt == 0)  m_kind = 2;
        else                                          m_kind = 0;
      end
      phase = (en_v != 0) ? ((phase < 2) ? phase + 1 : 2) : 0;
    end

    @(posedge clock);
    #1;
    stepno++;
    check("exp_out",      exp_out,      m_exp);
    check("chk_valid",    chk_valid,    (phase == 2) ? 1 : 0);
    check("err_mismatch", err_mismatch, m_mis);
    check("err_range",    err_range,    m_rng);
    check("err_sticky",   err_sticky,   m_sticky);
    check("err_cnt",      err_cnt,      m_ec);
    check("wrap_up_cnt",  wrap_up_cnt,  m_wu);
    check("wrap_dn_cnt",  wrap_dn_cnt,  m_wd);
    $display("step %0d rst=%0d en=%0d ld=%0d md=%0d d=%0d cnt=%0d exp_out=%0d chk=%0d mis=%0d rng=%0d ec=%0d wu=%0d wd=%0d",
             stepno, rst_v, en_v, ld_v, md_v, d_v, cnt, exp_out, chk_valid,
             err_mismatch, err_range, err_cnt, wrap_up_cnt, wrap_dn_cnt);

    cnt = (rst_v != 0) ? 0 : next_count(ld_v, md_v, d_v, cnt);
  endtask

  initial begin
    int wu0, ec0;
    reset = 1'b1; mon_en = 1'b0; load = 1'b0; mode = 1'b0;
    data_in = 4'd0; count_in = 4'd0;

    // Reset with monitoring on, then 30 up-steps
    step(1, 1, 0, 0, 0, -1);
    check("reset_chk_valid", chk_valid, 1);
    check("reset_exp_out", exp_out, 0);
    for (int i = 0; i < 30; i++) step(0, 1, 0, 0, 0, -1);
    check("up30_wrap_up", wrap_up_cnt, 2);
    check("up30_err_cnt", err_cnt, 0);

    // Down-counting from 0 through two 0->11 steps
    step(1, 1, 0, 1, 0, -1);
    for (int i = 0; i < 14; i++) step(0, 1, 0, 1, 0, -1);
    check("dn_wrap_dn", wrap_dn_cnt, 2);
    check("dn_err_cnt", err_cnt, 0);

    // Load 7 going down, then load 11 and an up-step
    step(0, 1, 1, 1, 7, -1);
    check("load7_exp", exp_out, 7);
    step(0, 1, 0, 1, 0, -1);
    check("after7_exp", exp_out, 6);
    step(0, 1, 1, 0, 11, -1);
    wu0 = int'(wrap_up_cnt);
    step(0, 1, 0, 0, 0, -1);
    check("load11_no_wrap", wrap_up_cnt, wu0);
    check("after11_exp", exp_out, 0);
    step(0, 1, 0, 0, 0, -1);
    check("upstep_wrap", wrap_up_cnt, wu0 + 1);

    // Forced mismatch: 5 observed where 3 is expected
    step(1, 1, 0, 0, 0, -1);
    step(0, 1, 1, 0, 3, -1);
    step(0, 1, 0, 0, 0, 5);
    check("force_mis", err_mismatch, 1);
    check("force_sticky", err_sticky, 1);
    check("force_err_cnt", err_cnt, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, -1);
    check("resync_err_cnt", err_cnt, 1);

    // Illegal load value 13 then up-steps from it
    ec0 = int'(err_cnt);
    step(0, 1, 1, 0, 13, -1);
    step(0, 1, 0, 0, 0, -1);
    check("load13_range", err_range, 1);
    check("load13_no_mis", err_mismatch, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, -1);
    check("illegal_err_cnt_grew", (int'(err_cnt) > ec0) ? 1 : 0, 1);

    // Monitor disable/enable sequence: IDLE -> ARM -> CHECK
    step(0, 0, 0, 0, 0, -1);
    check("disabled_chk", chk_valid, 0);
    step(0, 1, 0, 0, 0, -1);
    check("arm_chk", chk_valid, 0);
    step(0, 1, 0, 0, 0, -1);
    check("check_chk", chk_valid, 1);

    // 300 forced errors saturate err_cnt, then reset mid-run
    for (int i = 0; i < 300; i++) step(0, 1, 0, 0, 0, (m_exp + 1) % 12);
    check("sat_err_cnt", err_cnt, CMAX);
    step(1, 1, 0, 0, 0, -1);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_sticky", err_sticky, 0);
    check("rst_exp", exp_out, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r_rst, r_en, r_ld, r_md, r_d, r_f;
      r_rst = ($urandom_range(0, 99) < 2) ? 1 : 0;
      r_en  = ($urandom_range(0, 99) < 88) ? 1 : 0;
      r_ld  = ($urandom_range(0, 99) < 12) ? 1 : 0;
      r_md  = ($urandom_range(0, 99) < 40) ? 1 : 0;
      r_d   = (($urandom_range(0, 99) < 85) ? $urandom_range(0, 11) : $urandom_range(0, 15));
      r_f   = ($urandom_range(0, 99) < 6) ? int'($urandom_range(0, 15)) : -1;
      step(r_rst, r_en, r_ld, r_md, r_d, r_f);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
